// File: rtl/tree_walker.sv
// Decision-tree walker: reads nodes from a 1-cycle-latency ROM and follows split
// comparisons on IEEE-754 doubles until a leaf or error. Optional macro: TREE_WALKER_PATH_LEN_EN.
module tree_walker #(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int ROOT_ADDR  = 0,
    parameter int MAX_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [NODE_WIDTH-1:0] node_data,
    output logic [3:0]            feat_sel,
    input  logic [63:0]           feat_val,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  result_class,
    output logic                  result_err,
    output logic [5:0]            path_len
);

    localparam int DW = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  class_q, class_d;
    logic                  err_q, err_d;
    logic [3:0]            feat_sel_q, feat_sel_d;

    logic [3:0]  nd_feat;
    logic [63:0] nd_thr;
    logic [11:0] nd_left, nd_right, child;
    logic [3:0]  nd_type;
    logic        go_left, child_oob, at_limit, unused_hi;

    assign nd_feat   = node_data[95:92];
    assign nd_thr    = node_data[91:28];
    assign nd_left   = node_data[27:16];
    assign nd_right  = node_data[15:4];
    assign nd_type   = node_data[3:0];
    assign unused_hi = ^node_data[NODE_WIDTH-1:96];

    // Sign-magnitude doubles become unsigned-orderable by flipping all bits of
    // negatives and only the sign bit of positives.
    function automatic logic [63:0] order_key(input logic [63:0] x);
        return x[63] ? ~x : {1'b1, x[62:0]};
    endfunction

    // Keys order -0.0 below +0.0, so signed zeros are forced equal first.
    assign go_left   = ((feat_val[62:0] == '0) && (nd_thr[62:0] == '0)) ||
                       (order_key(feat_val) <= order_key(nd_thr));
    assign child     = go_left ? nd_left : nd_right;
    assign child_oob = (child >> ADDR_WIDTH) != '0;
    assign at_limit  = depth_q == DW'(MAX_DEPTH - 1);

`ifdef TREE_WALKER_PATH_LEN_EN
    logic [5:0] path_len_q, path_len_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        depth_d    = depth_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        class_d    = class_q;
        err_d      = err_q;
        feat_sel_d = feat_sel_q;
`ifdef TREE_WALKER_PATH_LEN_EN
        path_len_d = path_len_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: state_d = EVAL;
            EVAL: begin
                feat_sel_d = nd_feat;
                if (nd_type == 4'h3 && !at_limit && !child_oob) begin
                    addr_d  = ADDR_WIDTH'(child);
                    depth_d = depth_q + 1'b1;
                    state_d = WAIT;
                end else begin
                    valid_d = 1'b1;
                    state_d = DONE;
                    if (nd_type == 4'h0 || nd_type == 4'h1) begin
                        class_d = nd_type[0];
                        err_d   = 1'b0;
                    end else begin
                        class_d = 1'b0;
                        err_d   = 1'b1;
                    end
`ifdef TREE_WALKER_PATH_LEN_EN
                    path_len_d = 6'(depth_q) + 6'd1;
`endif
                end
            end
            DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= ADDR_WIDTH'(ROOT_ADDR);
            depth_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= 1'b0;
            err_q      <= 1'b0;
            feat_sel_q <= '0;
`ifdef TREE_WALKER_PATH_LEN_EN
            path_len_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            depth_q    <= depth_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            err_q      <= err_d;
            feat_sel_q <= feat_sel_d;
`ifdef TREE_WALKER_PATH_LEN_EN
            path_len_q <= path_len_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign addr         = addr_q;
    assign result_valid = valid_q;
    assign result_class = class_q;
    assign result_err   = err_q;
    assign feat_sel     = (state_q == EVAL) ? nd_feat : feat_sel_q;
`ifdef TREE_WALKER_PATH_LEN_EN
    assign path_len     = path_len_q;
`else
    assign path_len     = '0;
`endif

endmodule

// File: tb/tb_tree_walker.sv
// Scoreboard bench for tree_walker: behavioural tree ROM, per-feature value table,
// directed walks with hand-derived class/error/path_len/latency expectations.
module tb_tree_walker;

    localparam logic [63:0] D_192_5 = 64'h4068100000000000;
    localparam logic [63:0] D_193   = 64'h4068200000000000;
    localparam logic [63:0] D_1     = 64'h3FF0000000000000;
    localparam logic [63:0] D_1000  = 64'h408F400000000000;
    localparam logic [63:0] D_M1    = 64'hBFF0000000000000;
    localparam logic [63:0] D_M2    = 64'hC000000000000000;
    localparam logic [63:0] D_MHALF = 64'hBFE0000000000000;
    localparam logic [63:0] D_PZERO = 64'h0000000000000000;
    localparam logic [63:0] D_NZERO = 64'h8000000000000000;
`ifdef TREE_WALKER_PATH_LEN_EN
    localparam bit PLEN_EN = 1'b1;
`else
    localparam bit PLEN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic [9:0]   addr;
    logic [119:0] node_data;
    logic [3:0]   feat_sel;
    logic [63:0]  feat_val;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic         result_class;
    logic         result_err;
    logic [5:0]   path_len;

    logic [119:0] rom [0:63];
    logic [63:0]  fv_tab [0:15];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct packed {
        bit         cls;
        bit         err;
        logic [5:0] plen;
        int         t0;
        int         lat;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    bit   vprev = 1'b0;

    tree_walker #(.NODE_WIDTH(120), .ADDR_WIDTH(10), .ROOT_ADDR(0), .MAX_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .addr(addr),
        .node_data(node_data), .feat_sel(feat_sel), .feat_val(feat_val),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_err(result_err), .path_len(path_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) node_data <= rom[addr[5:0]];
    assign feat_val = fv_tab[feat_sel];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [119:0] mk(input logic [11:0] id, input logic [3:0] f,
                                        input logic [63:0] thr, input logic [11:0] l,
                                        input logic [11:0] r, input logic [3:0] t);
        return {12'hABC, id, f, thr, l, r, t};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mk(12'(i), 4'h0, '0, '0, '0, 4'hF);
        for (int i = 0; i < 16; i++) fv_tab[i] = D_1000;
    endtask

    task automatic basic_rom(input logic [3:0] f, input logic [63:0] thr);
        clear_rom();
        rom[0] = mk(12'd0, f, thr, 12'd1, 12'd2, 4'h3);
        rom[1] = mk(12'd1, 4'h0, '0, '0, '0, 4'h1);
        rom[2] = mk(12'd2, 4'h0, '0, '0, '0, 4'h0);
    endtask

    // Monitor: every rising result_valid pops one expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            vprev = 1'b0;
        end else begin
            if (result_valid && !vprev) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("class", 64'(result_class), 64'(mon_e.cls));
                    chk("err", 64'(result_err), 64'(mon_e.err));
                    chk("path_len", 64'(path_len), 64'(mon_e.plen));
                    chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                end
            end
            vprev = result_valid;
        end
    end

    task automatic walk(input bit ecls, input bit eerr, input int d, input int hold,
                        input bit poke, input int a2);
        exp_t e;
        int   n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        e.cls  = ecls;
        e.err  = eerr;
        e.plen = PLEN_EN ? 6'(d + 1) : 6'd0;
        e.t0   = cyc;
        e.lat  = 2 * (d + 1);
        sbq.push_back(e);
        chk("busy_on_accept", 64'(busy), 64'd1);
        chk("addr_root", 64'(addr), 64'd0);
        if (a2 >= 0) begin
            repeat (2) @(negedge clk);
            chk("addr_second", 64'(addr), 64'(a2));
        end
        n = 0;
        while (!result_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got no result after %0d cycles expected one", n);
        end
        for (int k = 0; k < hold; k++) begin
            start = poke && (k % 3 == 1);
            @(negedge clk);
            chk("hold_valid", 64'(result_valid), 64'd1);
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_class", 64'(result_class), 64'(ecls));
            chk("hold_err", 64'(result_err), 64'(eerr));
            chk("hold_plen", 64'(path_len), 64'(e.plen));
        end
        start = poke;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        chk("valid_clear", 64'(result_valid), 64'd0);
        chk("busy_clear", 64'(busy), 64'd0);
        @(negedge clk);
        chk("stay_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_class", 64'(result_class), 64'd0);
        chk("rst_err", 64'(result_err), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_feat_sel", 64'(feat_sel), 64'd0);
        chk("rst_path_len", 64'(path_len), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        basic_rom(4'd1, D_192_5);
        fv_tab[1] = D_192_5;
        walk(1'b1, 1'b0, 1, 0, 1'b0, -1);
        fv_tab[1] = D_193;
        walk(1'b0, 1'b0, 1, 0, 1'b0, 2);
        fv_tab[1] = D_192_5;
        walk(1'b1, 1'b0, 1, 10, 1'b1, -1);

        rom[0] = mk(12'd0, 4'd1, D_192_5, 12'd1, 12'd2, 4'h7);
        walk(1'b0, 1'b1, 0, 3, 1'b0, -1);

        clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = mk(12'(i), 4'd2, D_192_5, 12'(i + 1), 12'd63, 4'h3);
        fv_tab[2] = D_1;
        walk(1'b0, 1'b1, 31, 0, 1'b0, -1);

        basic_rom(4'd1, D_192_5);
        rom[0] = mk(12'd0, 4'd1, D_192_5, 12'hC01, 12'd2, 4'h3);
        fv_tab[1] = D_1;
        walk(1'b0, 1'b1, 0, 0, 1'b0, -1);

        basic_rom(4'd3, D_PZERO);
        fv_tab[3] = D_NZERO;
        walk(1'b1, 1'b0, 1, 0, 1'b0, -1);
        basic_rom(4'd3, D_NZERO);
        fv_tab[3] = D_PZERO;
        walk(1'b1, 1'b0, 1, 0, 1'b0, -1);
        basic_rom(4'd3, D_M1);
        fv_tab[3] = D_M2;
        walk(1'b1, 1'b0, 1, 0, 1'b0, -1);
        fv_tab[3] = D_MHALF;
        walk(1'b0, 1'b0, 1, 0, 1'b0, -1);

        // Abort a walk from WAIT, then confirm a clean restart.
        basic_rom(4'd1, D_192_5);
        fv_tab[1] = D_192_5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_addr", 64'(addr), 64'd0);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid || busy) bad++;
        end
        chk("abort_quiet", 64'(bad), 64'd0);
        walk(1'b1, 1'b0, 1, 0, 1'b0, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
